// File: rtl/unidad_control_pkg.sv
// Shared definitions for the multicycle ARM-subset control unit:
// FSM state encoding, ALU operation codes, data-processing cmd codes,
// condition codes and the datapath mux select encodings.
package unidad_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  // ALU operations (zero-extended to ALU_CTRL_W at the top level)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  // Data-processing cmd field, instruction [24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Condition codes, instruction [31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ALU B operand select
  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  // Writeback result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/unidad_control_multiciclo_cond_check.sv
// Registered NZCV flags and condition evaluation.
//   clk, rst     : clock, async active-high reset (flags -> 0000)
//   cond         : instruction condition field
//   alu_flags    : live ALU NZCV
//   wr_nz, wr_cv : load N/Z and C/V halves of the flag register
//   flags        : registered NZCV ([3]=N [2]=Z [1]=C [0]=V)
//   cond_ex      : cond holds against the registered flags
module cond_check
  import unidad_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       wr_nz,
  input  logic       wr_cv,
  output logic [3:0] flags,
  output logic       cond_ex
);

  // Split enables let logical ops update N/Z while preserving C/V.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else begin
      if (wr_nz) flags[3:2] <= alu_flags[3:2];
      if (wr_cv) flags[1:0] <= alu_flags[1:0];
    end
  end

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 1111 never executes
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, output
// decode for the shared datapath, condition-gated writes, mem_ready stalls.
//   clk, rst          : clock, async active-high reset
//   cond, op, funct, rd, ALU_flags, mem_ready : instruction fields / status
//   PC_write, adr_src, IR_write, mem_write, reg_write : enables and address select
//   ALU_src_A, ALU_src_B, result_src, imm_src, reg_src, ALU_control : selects
//   illegal_instr     : one-cycle pulse in DECODE on an undecodable instruction
module unidad_control_multiciclo
  import unidad_control_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter bit HAS_EOR_MOV = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            ALU_flags,
  input  logic                  mem_ready,
  output logic                  PC_write,
  output logic                  adr_src,
  output logic                  IR_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  ALU_src_A,
  output logic [1:0]            ALU_src_B,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] ALU_control,
  output logic                  illegal_instr
);

  state_t     state, state_nxt;
  logic       cond_ex, wr_nz, wr_cv;
  logic [3:0] flags;

  cond_check u_cc (
    .clk      (clk),
    .rst      (rst),
    .cond     (cond),
    .alu_flags(ALU_flags),
    .wr_nz    (wr_nz),
    .wr_cv    (wr_cv),
    .flags    (flags),
    .cond_ex  (cond_ex)
  );

  // Data-processing cmd decode
  logic [3:0] cmd;
  logic       s_bit, cmd_ok, is_cmp, is_logic;
  logic [2:0] dp_op, alu_sel;
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    dp_op    = ALU_ADD;
    cmd_ok   = 1'b1;
    is_cmp   = 1'b0;
    is_logic = 1'b0;
    case (cmd)
      CMD_ADD: dp_op = ALU_ADD;
      CMD_SUB: dp_op = ALU_SUB;
      CMD_CMP: begin dp_op = ALU_SUB; is_cmp = 1'b1; end
      CMD_AND: begin dp_op = ALU_AND; is_logic = 1'b1; end
      CMD_ORR: begin dp_op = ALU_ORR; is_logic = 1'b1; end
      CMD_EOR: begin dp_op = ALU_EOR; is_logic = 1'b1; cmd_ok = HAS_EOR_MOV; end
      CMD_MOV: begin dp_op = ALU_MOV; is_logic = 1'b1; cmd_ok = HAS_EOR_MOV; end
      default: cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    PC_write      = 1'b0;
    adr_src       = 1'b0;
    IR_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    ALU_src_A     = 1'b0;
    ALU_src_B     = SRCB_RM;
    result_src    = RES_ALUOUT;
    imm_src       = op;
    reg_src       = 2'b00;
    alu_sel       = ALU_ADD;
    illegal_instr = 1'b0;
    wr_nz         = 1'b0;
    wr_cv         = 1'b0;
    case (state)
      S_FETCH: begin
        ALU_src_A  = 1'b1;
        ALU_src_B  = SRCB_4;
        result_src = RES_ALU;
        IR_write   = mem_ready;
        PC_write   = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALU_src_A = 1'b1;
        ALU_src_B = SRCB_4;
        case (op)
          2'b00: begin
            if (!cmd_ok) begin
              illegal_instr = 1'b1;
              state_nxt     = S_FETCH;
            end else begin
              state_nxt = funct[5] ? S_EXECI : S_EXECR;
            end
          end
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: begin illegal_instr = 1'b1; state_nxt = S_FETCH; end
        endcase
      end
      S_EXECR: begin
        alu_sel   = dp_op;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALU_src_B = SRCB_IMM;
        alu_sel   = dp_op;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        // Keep the EXEC operand/op selects so the live ALU_flags sampled
        // here still belong to this instruction's operation.
        ALU_src_B = funct[5] ? SRCB_IMM : SRCB_RM;
        alu_sel   = dp_op;
        if (!is_cmp) begin
          if (rd == 4'd15) PC_write  = cond_ex;
          else             reg_write = cond_ex;
        end
        wr_nz     = cond_ex & (is_cmp | s_bit);
        wr_cv     = cond_ex & (is_cmp | s_bit) & ~is_logic;
        state_nxt = S_FETCH;
      end
      S_MEMADR: begin
        ALU_src_B = SRCB_IMM;
        state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        if (rd == 4'd15) PC_write  = cond_ex;
        else             reg_write = cond_ex;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        reg_src   = 2'b10;
        mem_write = cond_ex;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        reg_src    = 2'b01;
        ALU_src_B  = SRCB_IMM;
        result_src = RES_ALU;
        PC_write   = cond_ex;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset overrides everything combinationally so an in-flight access
    // is cut off in the same cycle rst rises.
    if (rst) begin
      PC_write      = 1'b0;
      adr_src       = 1'b0;
      IR_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      ALU_src_A     = 1'b0;
      ALU_src_B     = 2'b00;
      result_src    = 2'b00;
      imm_src       = 2'b00;
      reg_src       = 2'b00;
      alu_sel       = 3'd0;
      illegal_instr = 1'b0;
      wr_nz         = 1'b0;
      wr_cv         = 1'b0;
    end
  end

  assign ALU_control = ALU_CTRL_W'(alu_sel);

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: walks instructions through
// the FSM cycle by cycle and checks outputs against hand-computed values.
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cond, rd, ALU_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PC_write, adr_src, IR_write, mem_write, reg_write, ALU_src_A, illegal_instr;
  logic [1:0] ALU_src_B, result_src, imm_src, reg_src;
  logic [3:0] ALU_control;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.ALU_CTRL_W(4), .HAS_EOR_MOV(1'b1)) dut (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .ALU_flags(ALU_flags), .mem_ready(mem_ready),
    .PC_write(PC_write), .adr_src(adr_src), .IR_write(IR_write),
    .mem_write(mem_write), .reg_write(reg_write), .ALU_src_A(ALU_src_A),
    .ALU_src_B(ALU_src_B), .result_src(result_src), .imm_src(imm_src),
    .reg_src(reg_src), .ALU_control(ALU_control), .illegal_instr(illegal_instr)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] r);
    cond = c; op = o; funct = f; rd = r;
  endtask

  // Starts in FETCH; ends one cycle past DECODE.
  task automatic do_fetch(input string t);
    mem_ready = 1'b1; #1;
    chk({t, ".f_irw"},  IR_write, 1);
    chk({t, ".f_pcw"},  PC_write, 1);
    chk({t, ".f_srcb"}, ALU_src_B, 2);
    tick;
    chk({t, ".d_irw"}, IR_write, 0);
    chk({t, ".d_ill"}, illegal_instr, 0);
    tick;
  endtask

  task automatic run_dp(input string t, input logic [3:0] c, input logic [5:0] f,
                        input logic [3:0] r, input logic [3:0] af, input logic [3:0] exp_alu,
                        input logic [1:0] exp_srcb, input logic exp_rw, input logic exp_pcw);
    load(c, 2'b00, f, r);
    ALU_flags = af;
    do_fetch(t);
    chk({t, ".e_alu"},  ALU_control, exp_alu);
    chk({t, ".e_srcb"}, ALU_src_B, exp_srcb);
    chk({t, ".e_rw"},   reg_write, 0);
    tick;
    chk({t, ".wb_rw"},  reg_write, exp_rw);
    chk({t, ".wb_pcw"}, PC_write, exp_pcw);
    tick;
  endtask

  task automatic run_br(input string t, input logic [3:0] c, input logic exp_pcw);
    load(c, 2'b10, 6'b100000, 4'd0);
    do_fetch(t);
    chk({t, ".b_pcw"},  PC_write, exp_pcw);
    chk({t, ".b_rsrc"}, reg_src, 1);
    chk({t, ".b_rw"},   reg_write, 0);
    tick;
    // Third cycle after fetch start must be FETCH again
    chk({t, ".back_f"}, IR_write, 1);
  endtask

  task automatic run_str(input string t, input logic [3:0] c, input logic exp_mw);
    load(c, 2'b01, 6'b011000, 4'd6);
    do_fetch(t);
    chk({t, ".ma_srcb"}, ALU_src_B, 1);
    tick;
    mem_ready = 1'b0; #1;
    chk({t, ".w0_mw"},  mem_write, exp_mw);
    chk({t, ".w0_adr"}, adr_src, 1);
    chk({t, ".w0_rs"},  reg_src, 2);
    tick;
    chk({t, ".w1_mw"},  mem_write, exp_mw);
    mem_ready = 1'b1;
    tick;
    chk({t, ".back_f"}, IR_write, 1);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; ALU_flags = 4'h0;
    load(4'b1110, 2'b00, 6'b001001, 4'd1);
    #2;
    chk("rst.irw",  IR_write, 0);
    chk("rst.pcw",  PC_write, 0);
    chk("rst.srcb", ALU_src_B, 0);
    chk("rst.res",  result_src, 0);
    chk("rst.srca", ALU_src_A, 0);
    tick;
    rst = 1'b0; #1;

    // ADDS R1: flags <- 0110
    run_dp("adds", 4'b1110, 6'b001001, 4'd1, 4'b0110, 4'd0, 2'b00, 1'b1, 1'b0);
    run_br("beq1", 4'b0000, 1'b1);   // Z=1
    run_br("bne1", 4'b0001, 1'b0);

    // LDR with two MEMRD stall cycles: 7 cycles total
    load(4'b1110, 2'b01, 6'b011001, 4'd2);
    do_fetch("ldr");                       // cycles 1-2
    chk("ldr.ma_srca", ALU_src_A, 0);      // cycle 3
    chk("ldr.ma_srcb", ALU_src_B, 1);
    tick;
    mem_ready = 1'b0; #1;                  // cycle 4
    chk("ldr.r0_adr", adr_src, 1);
    chk("ldr.r0_rw",  reg_write, 0);
    tick;                                  // cycle 5
    chk("ldr.r1_adr", adr_src, 1);
    tick;                                  // cycle 6
    mem_ready = 1'b1; #1;
    chk("ldr.r2_rw",  reg_write, 0);
    tick;                                  // cycle 7
    chk("ldr.wb_rw",  reg_write, 1);
    chk("ldr.wb_res", result_src, 1);
    tick;
    chk("ldr.back_f", IR_write, 1);

    // FETCH stall
    mem_ready = 1'b0; #1;
    chk("fstall.irw", IR_write, 0);
    chk("fstall.pcw", PC_write, 0);
    tick;
    chk("fstall.hold", ALU_src_B, 2);

    // SUBS: flags <- 0111 ; ANDS (N=1,Z=0): flags <- 1011 (C,V kept)
    run_dp("subs", 4'b1110, 6'b000101, 4'd3, 4'b0111, 4'd1, 2'b00, 1'b1, 1'b0);
    run_dp("ands", 4'b1110, 6'b000001, 4'd4, 4'b1000, 4'd2, 2'b00, 1'b1, 1'b0);
    run_br("bne2", 4'b0001, 1'b1);
    run_br("bvs",  4'b0110, 1'b1);
    run_br("bcs",  4'b0010, 1'b1);
    run_br("bvc",  4'b0111, 1'b0);
    run_br("bmi",  4'b0100, 1'b1);
    run_br("bge",  4'b1010, 1'b1);
    run_br("blt",  4'b1011, 1'b0);
    run_br("bnv",  4'b1111, 1'b0);
    run_str("streq", 4'b0000, 1'b0);   // Z=0 -> suppressed

    // CMP: no reg write, flags <- 0100
    run_dp("cmp", 4'b1110, 6'b010101, 4'd0, 4'b0100, 4'd1, 2'b00, 1'b0, 1'b0);
    run_br("beq2", 4'b0000, 1'b1);
    run_br("bcc",  4'b0011, 1'b1);
    // MOV imm, S=0: flags untouched
    run_dp("movi", 4'b1110, 6'b111010, 4'd5, 4'b1111, 4'd5, 2'b01, 1'b1, 1'b0);
    run_br("beq3", 4'b0000, 1'b1);
    // EOR reg, ORR under failing NE
    run_dp("eor",  4'b1110, 6'b000010, 4'd7, 4'b0000, 4'd4, 2'b00, 1'b1, 1'b0);
    run_dp("orrne", 4'b0001, 6'b011000, 4'd8, 4'b0000, 4'd3, 2'b00, 1'b0, 1'b0);

    // ADD to PC: PC_write instead of reg_write, result_src=00
    load(4'b1110, 2'b00, 6'b001000, 4'd15);
    do_fetch("addpc");
    tick;
    chk("addpc.pcw", PC_write, 1);
    chk("addpc.rw",  reg_write, 0);
    chk("addpc.res", result_src, 0);
    tick;

    // op=11 illegal
    load(4'b1110, 2'b11, 6'b000000, 4'd1);
    tick; // fetch
    chk("ill.d_pulse", illegal_instr, 1);
    chk("ill.d_rw",    reg_write, 0);
    chk("ill.d_pcw",   PC_write, 0);
    tick;
    chk("ill.back_f", IR_write, 1);
    chk("ill.clear",  illegal_instr, 0);
    // undecodable cmd 0011
    load(4'b1110, 2'b00, 6'b000110, 4'd1);
    tick;
    chk("illcmd.pulse", illegal_instr, 1);
    tick;
    chk("illcmd.back_f", IR_write, 1);

    // STR AL with reset during MEMWR
    run_str("stral", 4'b1110, 1'b1);
    load(4'b1110, 2'b01, 6'b011000, 4'd6);
    do_fetch("strrst");
    tick;
    mem_ready = 1'b0; #1;
    chk("strrst.mw_pre", mem_write, 1);
    rst = 1'b1; #1;
    chk("strrst.mw_rst", mem_write, 0);
    chk("strrst.adr",    adr_src, 0);
    tick;
    rst = 1'b0; mem_ready = 1'b1; #1;
    chk("strrst.f_irw",  IR_write, 1);
    chk("strrst.f_srca", ALU_src_A, 1);
    run_br("beq_rst", 4'b0000, 1'b0);  // flags cleared by reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
